// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared state encodings, requester ids and default sizes
package mem_port_arbiter_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2,
        RESP    = 2'd3
    } state_t;
    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_IF   = 2'd1,
        REQ_D    = 2'd2
    } req_id_t;
    localparam int DEF_ADDR_W       = 16;
    localparam int DEF_DATA_W       = 16;
    localparam int DEF_STARVE_LIMIT = 4;
endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating count of data grants taken while a fetch waits
module arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] cnt;
    assign at_limit = cnt == W'(LIMIT);
    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (inc && !at_limit) cnt <= cnt + W'(1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data paths,
// data first, with fetch forced after STARVE_LIMIT consecutive data grants.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);
    state_t state, next;
    logic arb, busy, done, pick_d, pick_if, at_limit;

    assign arb     = state == IDLE || state == RESP;
    assign busy    = state == BUSY_IF || state == BUSY_D;
    assign done    = busy && mem_ready;
    assign pick_d  = arb && d_req && !(if_req && at_limit);
    assign pick_if = arb && if_req && !pick_d;
    assign if_stall = if_req & ~if_valid;

    arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk(clk),
        .rst(rst),
        .inc(pick_d && if_req),
        .clr(arb && (pick_if || !if_req)),
        .at_limit(at_limit)
    );

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= next;

    always_comb begin
        next = state;
        if (arb) next = pick_d ? BUSY_D : pick_if ? BUSY_IF : IDLE;
        else if (done) next = RESP;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            if_gnt    <= 1'b0;
            d_gnt     <= 1'b0;
            if_valid  <= 1'b0;
            d_valid   <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if_gnt   <= pick_if;
            d_gnt    <= pick_d;
            if_valid <= done && state == BUSY_IF;
            d_valid  <= done && state == BUSY_D;
            if (pick_d || pick_if) begin
                mem_en   <= 1'b1;
                mem_we   <= pick_d && d_we;
                mem_addr <= pick_d ? d_addr : if_addr;
                if (pick_d) mem_wdata <= d_wdata;
            end else if (done) begin
                mem_en <= 1'b0;
                mem_we <= 1'b0;
            end
            // stores leave the load-data register untouched
            if (done && state == BUSY_IF) if_rdata <= mem_rdata;
            if (done && state == BUSY_D && !mem_we) d_rdata <= mem_rdata;
        end
endmodule
